// File: rtl/rtl_settings_pkg.sv
// Shared types and constants for the burst compare engine.
//   cmp_mode_t     : expected-pattern generator mode
//   cmp_desc_t     : one queued read descriptor
//   CMP_*          : descriptor field widths; the engine's DATA_W/ADDR_W/BURST_W
//                    parameters must match these
//   expand_byteen  : widen a byte-enable vector to a bit mask
package rtl_settings_pkg;

  localparam int unsigned CMP_DATA_W  = 128;
  localparam int unsigned CMP_ADDR_W  = 32;
  localparam int unsigned CMP_BURST_W = 8;
  localparam int unsigned CMP_LANES   = CMP_DATA_W / 32;
  localparam int unsigned CMP_BYTES   = CMP_DATA_W / 8;

  typedef enum logic [1:0] {
    CMP_FIXED = 2'd0,
    CMP_INCR  = 2'd1,
    CMP_ADDR  = 2'd2,
    CMP_ALT   = 2'd3
  } cmp_mode_t;

  typedef struct packed {
    logic [CMP_ADDR_W-1:0]  addr;
    logic [CMP_BURST_W-1:0] burst;
    logic [CMP_BYTES-1:0]   byteen;
    cmp_mode_t              mode;
    logic [31:0]            pattern;
  } cmp_desc_t;

  function automatic logic [CMP_DATA_W-1:0] expand_byteen(input logic [CMP_BYTES-1:0] be);
    logic [CMP_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < CMP_BYTES; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/cmp_desc_fifo.sv
// Synchronous descriptor FIFO for the burst compare engine.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous empty (same effect as reset on the pointers)
//   push/pop   : enqueue push_desc / drop head; caller guarantees no push when full
//   head       : oldest entry, valid while !empty
//   full/empty : registered-pointer status, so they change only after a clock edge
module cmp_desc_fifo
  import rtl_settings_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  cmp_desc_t push_desc,
  input  logic      pop,
  output cmp_desc_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  cmp_desc_t      mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_desc;
  end

  assign head  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/burst_compare_engine.sv
// Burst read-data compare engine.
// Queues read descriptors and checks every returned beat against a locally
// generated pattern (FIXED / INCR / ADDR / ALT), masked by byte enables.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   test_start_i           : one-cycle flush-and-clear
//   cmp_valid_i/ready_o    : descriptor handshake (addr, burst, byteen, mode, pattern)
//   readdatavalid_i/data_i : returned read beats
//   busy_o                 : descriptors queued or a beat in the compare stage
//   err_o, unexpected_o    : sticky error / beat-with-empty-queue flags
//   err_cnt_o              : saturating count of failing beats
//   err_addr/exp/rd_o      : capture of the first failing beat
// Optional build macro CMP_BYTE_STATS_EN adds err_bytes_o, a sticky OR of the
// mismatching byte lanes.
// Pipeline: beat + expected data register on arrival, the mismatch decision
// registers into the result outputs on the following edge.
module burst_compare_engine
  import rtl_settings_pkg::*;
#(
  parameter int unsigned DATA_W      = CMP_DATA_W,
  parameter int unsigned ADDR_W      = CMP_ADDR_W,
  parameter int unsigned BURST_W     = CMP_BURST_W,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_start_i,
  input  logic                  cmp_valid_i,
  output logic                  cmp_ready_o,
  input  logic [ADDR_W-1:0]     cmp_addr_i,
  input  logic [BURST_W-1:0]    cmp_burst_i,
  input  logic [DATA_W/8-1:0]   cmp_byteen_i,
  input  logic [1:0]            cmp_mode_i,
  input  logic [31:0]           cmp_pattern_i,
  input  logic                  readdatavalid_i,
  input  logic [DATA_W-1:0]     readdata_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  unexpected_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [DATA_W-1:0]     err_exp_o,
  output logic [DATA_W-1:0]     err_rd_o
`ifdef CMP_BYTE_STATS_EN
  ,
  output logic [DATA_W/8-1:0]   err_bytes_o
`endif
);

  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam logic [BURST_W-1:0]   BURST_ONE = 1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE   = 1;

  cmp_desc_t push_desc;
  cmp_desc_t head;
  logic      q_full;
  logic      q_empty;
  logic      push;
  logic      pop;

  logic [BURST_W-1:0] beat_cnt;
  logic               beat_hit;
  logic               last_beat;
  logic [DATA_W-1:0]  exp_data;
  logic [ADDR_W-1:0]  beat_addr;

  logic               s1_valid;
  logic               s1_unexp;
  logic [ADDR_W-1:0]  s1_addr;
  logic [DATA_W-1:0]  s1_exp;
  logic [DATA_W-1:0]  s1_rd;
  logic [BYTES-1:0]   s1_byteen;

  logic [DATA_W-1:0]  diff;
  logic               err_hit;
  logic               err_beat;

  assign push_desc = '{addr:    cmp_addr_i,
                       burst:   cmp_burst_i,
                       byteen:  cmp_byteen_i,
                       mode:    cmp_mode_t'(cmp_mode_i),
                       pattern: cmp_pattern_i};

  // test_start_i wins over anything arriving in the same cycle.
  assign push = cmp_valid_i && cmp_ready_o && !test_start_i;

  cmp_desc_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_desc_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (test_start_i),
    .push      (push),
    .push_desc (push_desc),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign cmp_ready_o = !q_full;

  // A burst of 0 is one beat, which the <= 1 test covers together with burst 1.
  assign beat_hit  = readdatavalid_i && !test_start_i && !q_empty;
  assign last_beat = (head.burst <= BURST_ONE) || (beat_cnt == head.burst - BURST_ONE);
  assign pop       = beat_hit && last_beat;
  assign beat_addr = head.addr + ADDR_W'(beat_cnt) * ADDR_W'(BYTES);

  always_comb begin
    exp_data = '0;
    for (int k = 0; k < LANES; k++) begin
      case (head.mode)
        CMP_FIXED: exp_data[32*k +: 32] = head.pattern;
        CMP_INCR:  exp_data[32*k +: 32] = head.pattern + 32'(beat_cnt) * 32'(LANES) + 32'(k);
        CMP_ADDR:  exp_data[32*k +: 32] = 32'(head.addr) + 32'(beat_cnt) * 32'(BYTES) + 32'(4 * k);
        default:   exp_data[32*k +: 32] = beat_cnt[0] ? ~head.pattern : head.pattern;
      endcase
    end
  end

  // Compare stage. Beats with an empty queue still occupy the stage so they
  // can be counted, but their data is never captured.
  always_ff @(posedge clk_i) begin
    if (rst_i || test_start_i) begin
      beat_cnt  <= '0;
      s1_valid  <= 1'b0;
      s1_unexp  <= 1'b0;
      s1_addr   <= '0;
      s1_exp    <= '0;
      s1_rd     <= '0;
      s1_byteen <= '0;
    end else begin
      s1_valid <= readdatavalid_i;
      s1_unexp <= readdatavalid_i && q_empty;
      if (beat_hit) begin
        s1_addr   <= beat_addr;
        s1_exp    <= exp_data;
        s1_rd     <= readdata_i;
        s1_byteen <= head.byteen;
        beat_cnt  <= last_beat ? '0 : beat_cnt + BURST_ONE;
      end
    end
  end

  assign diff     = (s1_rd ^ s1_exp) & expand_byteen(s1_byteen);
  assign err_hit  = s1_valid && !s1_unexp && (|diff);
  assign err_beat = err_hit || (s1_valid && s1_unexp);
  assign busy_o   = !q_empty || s1_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i || test_start_i) begin
      err_o        <= 1'b0;
      unexpected_o <= 1'b0;
      err_cnt_o    <= '0;
      err_addr_o   <= '0;
      err_exp_o    <= '0;
      err_rd_o     <= '0;
    end else if (err_beat) begin
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_ONE;
      err_o <= 1'b1;
      if (s1_unexp) begin
        unexpected_o <= 1'b1;
      end else if (!err_o) begin
        err_addr_o <= s1_addr;
        err_exp_o  <= s1_exp;
        err_rd_o   <= s1_rd;
      end
    end
  end

`ifdef CMP_BYTE_STATS_EN
  logic [BYTES-1:0] byte_diff;

  always_comb begin
    byte_diff = '0;
    for (int i = 0; i < BYTES; i++) begin
      byte_diff[i] = |diff[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || test_start_i) begin
      err_bytes_o <= '0;
    end else if (err_hit) begin
      err_bytes_o <= err_bytes_o | byte_diff;
    end
  end
`endif

endmodule

// File: tb/tb_burst_compare_engine.sv
module tb_burst_compare_engine;

  localparam int QD  = 8;
  localparam int ECW = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         test_start_i;
  logic         cmp_valid_i;
  logic         cmp_ready_o;
  logic [31:0]  cmp_addr_i;
  logic [7:0]   cmp_burst_i;
  logic [15:0]  cmp_byteen_i;
  logic [1:0]   cmp_mode_i;
  logic [31:0]  cmp_pattern_i;
  logic         readdatavalid_i;
  logic [127:0] readdata_i;
  logic         busy_o;
  logic         err_o;
  logic         unexpected_o;
  logic [ECW-1:0] err_cnt_o;
  logic [31:0]  err_addr_o;
  logic [127:0] err_exp_o;
  logic [127:0] err_rd_o;
`ifdef CMP_BYTE_STATS_EN
  logic [15:0]  err_bytes_o;
`endif

  burst_compare_engine #(
    .DATA_W(128), .ADDR_W(32), .BURST_W(8), .QUEUE_DEPTH(QD), .ERR_CNT_W(ECW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .test_start_i    (test_start_i),
    .cmp_valid_i     (cmp_valid_i),
    .cmp_ready_o     (cmp_ready_o),
    .cmp_addr_i      (cmp_addr_i),
    .cmp_burst_i     (cmp_burst_i),
    .cmp_byteen_i    (cmp_byteen_i),
    .cmp_mode_i      (cmp_mode_i),
    .cmp_pattern_i   (cmp_pattern_i),
    .readdatavalid_i (readdatavalid_i),
    .readdata_i      (readdata_i),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .unexpected_o    (unexpected_o),
    .err_cnt_o       (err_cnt_o),
    .err_addr_o      (err_addr_o),
    .err_exp_o       (err_exp_o),
    .err_rd_o        (err_rd_o)
`ifdef CMP_BYTE_STATS_EN
    ,
    .err_bytes_o     (err_bytes_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          burst;
    logic [15:0] byteen;
    int          mode;
    logic [31:0] pattern;
  } desc_t;

  typedef struct {
    logic         err;
    logic         unexp;
    logic [ECW-1:0] cnt;
    logic [31:0]  addr;
    logic [127:0] exp;
    logic [127:0] rd;
    logic [15:0]  bytes;
  } snap_t;

  // Reference model state: what the result registers should hold.
  desc_t mq[$];
  int    m_beat;
  snap_t m;
  snap_t sb[$];
  bit    prev_beat;
  desc_t nod;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_exp(input desc_t d, input int b);
    logic [127:0] r;
    logic [31:0]  v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      case (d.mode)
        0:       v = d.pattern;
        1:       v = d.pattern + 32'(b * 4 + k);
        2:       v = d.addr + 32'(b * 16 + 4 * k);
        default: v = (b % 2 == 1) ? ~d.pattern : d.pattern;
      endcase
      r[32*k +: 32] = v;
    end
    return r;
  endfunction

  function automatic logic [127:0] cur_exp();
    return model_exp(mq[0], m_beat);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_beat = 0;
    m = '{err: 1'b0, unexp: 1'b0, cnt: '0, addr: '0, exp: '0, rd: '0, bytes: '0};
  endtask

  task automatic model_beat(input logic [127:0] data);
    desc_t        d;
    logic [127:0] e;
    logic [127:0] diff;
    int           nbeats;
    if (mq.size() == 0) begin
      m.unexp = 1'b1;
      m.err   = 1'b1;
      if (m.cnt != '1) m.cnt++;
    end else begin
      d = mq[0];
      e = model_exp(d, m_beat);
      diff = '0;
      for (int i = 0; i < 16; i++)
        if (d.byteen[i]) diff[8*i +: 8] = data[8*i +: 8] ^ e[8*i +: 8];
      if (diff != 0) begin
        if (m.cnt != '1) m.cnt++;
        if (!m.err) begin
          m.addr = d.addr + 32'(m_beat * 16);
          m.exp  = e;
          m.rd   = data;
        end
        m.err = 1'b1;
        for (int i = 0; i < 16; i++)
          if (diff[8*i +: 8] != 0) m.bytes[i] = 1'b1;
      end
      m_beat++;
      nbeats = (d.burst == 0) ? 1 : d.burst;
      if (m_beat >= nbeats) begin
        void'(mq.pop_front());
        m_beat = 0;
      end
    end
    sb.push_back(m);
  endtask

  // One clock cycle of stimulus; model updated with the pre-edge queue state.
  task automatic cycle(input bit do_push, input desc_t d, input bit do_beat,
                       input logic [127:0] data, input bit do_start);
    bit rdy;
    rdy = (mq.size() < QD);
    chk("ready", 128'(cmp_ready_o), 128'(rdy));
    chk("busy", 128'(busy_o), 128'((mq.size() != 0) || prev_beat));
    cmp_valid_i     = do_push;
    cmp_addr_i      = d.addr;
    cmp_burst_i     = 8'(d.burst);
    cmp_byteen_i    = d.byteen;
    cmp_mode_i      = 2'(d.mode);
    cmp_pattern_i   = d.pattern;
    readdatavalid_i = do_beat;
    readdata_i      = data;
    test_start_i    = do_start;
    if (do_start) begin
      model_clear();
      sb.push_back(m);
    end else begin
      if (do_beat) model_beat(data);
      if (do_push && rdy) mq.push_back(d);
    end
    prev_beat = do_beat && !do_start;
    @(posedge clk_i);
    #1;
    cmp_valid_i     = 1'b0;
    readdatavalid_i = 1'b0;
    test_start_i    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, nod, 0, '0, 0);
  endtask

  task automatic start();
    if (prev_beat) idle(1);
    cycle(0, nod, 0, '0, 1);
  endtask

  task automatic push(input desc_t d);
    cycle(1, d, 0, '0, 0);
  endtask

  task automatic beat(input logic [127:0] data);
    cycle(0, nod, 1, data, 0);
  endtask

  function automatic desc_t mk(input int mode, input logic [31:0] pat, input logic [31:0] addr,
                               input int burst, input logic [15:0] be);
    desc_t d;
    d.mode = mode; d.pattern = pat; d.addr = addr; d.burst = burst; d.byteen = be;
    return d;
  endfunction

  // Monitor: a beat's result is visible after the second edge following it.
  bit sh1 = 0, sh2 = 0, st = 0;
  always @(posedge clk_i) begin
    sh2 = sh1;
    sh1 = readdatavalid_i && !test_start_i && !rst_i;
    st  = test_start_i && !rst_i;
    if (test_start_i || rst_i) sh2 = 0;
  end

  always @(negedge clk_i) begin
    snap_t s;
    if (sh2 || st) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: actual=empty required=entry at %0t", $time);
      end else begin
        s = sb.pop_front();
        chk("err_o", 128'(err_o), 128'(s.err));
        chk("unexpected_o", 128'(unexpected_o), 128'(s.unexp));
        chk("err_cnt_o", 128'(err_cnt_o), 128'(s.cnt));
        chk("err_addr_o", 128'(err_addr_o), 128'(s.addr));
        chk("err_exp_o", err_exp_o, s.exp);
        chk("err_rd_o", err_rd_o, s.rd);
`ifdef CMP_BYTE_STATS_EN
        chk("err_bytes_o", 128'(err_bytes_o), 128'(s.bytes));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d;
    desc_t        r;
    bit           dp, db;
    nod = mk(0, '0, '0, 0, '0);
    model_clear();
    prev_beat       = 0;
    rst_i           = 1'b1;
    test_start_i    = 1'b0;
    cmp_valid_i     = 1'b0;
    cmp_addr_i      = '0;
    cmp_burst_i     = '0;
    cmp_byteen_i    = '0;
    cmp_mode_i      = '0;
    cmp_pattern_i   = '0;
    readdatavalid_i = 1'b0;
    readdata_i      = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_ready", 128'(cmp_ready_o), 128'(1));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_cnt", 128'(err_cnt_o), 128'(0));
    chk("rst_unexp", 128'(unexpected_o), 128'(0));

    // 1: FIXED, matching burst of 4; busy drop checked each cycle.
    push(mk(0, 32'hA5A55A5A, 32'h100, 4, 16'hFFFF));
    for (int b = 0; b < 4; b++) beat(cur_exp());
    idle(3);
    chk("t1_err", 128'(err_o), 128'(0));
    chk("t1_busy", 128'(busy_o), 128'(0));

    // 2: INCR, corrupt lane 2 of beat 1.
    start();
    push(mk(1, 32'h10, 32'h100, 2, 16'hFFFF));
    beat(cur_exp());
    d = cur_exp();
    chk("t2_exp_beat1", d, 128'h00000017_00000016_00000015_00000014);
    beat(d ^ (128'h1 << 67));
    idle(3);
    chk("t2_addr", 128'(err_addr_o), 128'h110);
    chk("t2_cnt", 128'(err_cnt_o), 128'd1);
    chk("t2_exp", err_exp_o, 128'h00000017_00000016_00000015_00000014);

    // 3: byte enables mask all but byte 0..3.
    start();
    push(mk(0, 32'hC0DE1234, 32'h40, 2, 16'h000F));
    d = {$urandom, $urandom, $urandom, 32'hC0DE1234};
    beat(d);
    d = {$urandom, $urandom, $urandom, 32'hC0DE1234 ^ 32'h1};
    beat(d);
    idle(3);
    chk("t3_cnt", 128'(err_cnt_o), 128'd1);
`ifdef CMP_BYTE_STATS_EN
    chk("t3_bytes", 128'(err_bytes_o), 128'h1);
`endif

    // 4: fill the queue, then pop one, then push+pop together.
    start();
    for (int i = 0; i < QD; i++) push(mk(0, 32'(i), 32'(i * 64), 1, 16'hFFFF));
    chk("t4_full", 128'(cmp_ready_o), 128'(0));
    beat(cur_exp());
    chk("t4_ready_after_pop", 128'(cmp_ready_o), 128'(1));
    cycle(1, mk(3, 32'h5555AAAA, 32'h0, 3, 16'hFFFF), 1, cur_exp(), 0);
    chk("t4_ready_pushpop", 128'(cmp_ready_o), 128'(1));
    while (mq.size() != 0) beat(cur_exp());
    idle(3);

    // 5: unexpected beats, then counter saturation.
    start();
    beat({4{$urandom}});
    idle(2);
    chk("t5_unexp", 128'(unexpected_o), 128'(1));
    chk("t5_addr", 128'(err_addr_o), 128'(0));
    for (int i = 0; i < 20; i++) beat({4{$urandom}});
    idle(2);
    chk("t5_sat", 128'(err_cnt_o), 128'hF);

    // 6: abort mid-burst, then a clean burst.
    start();
    push(mk(1, 32'h1000, 32'h200, 4, 16'hFFFF));
    beat(~cur_exp());
    beat(~cur_exp());
    idle(1);
    cycle(0, nod, 1, {4{$urandom}}, 1);
    chk("t6_err", 128'(err_o), 128'(0));
    chk("t6_cnt", 128'(err_cnt_o), 128'(0));
    chk("t6_busy", 128'(busy_o), 128'(0));
    push(mk(2, 32'h0, 32'hFFFFFFF0, 2, 16'hFFFF));
    beat(cur_exp());
    beat(cur_exp());
    idle(3);
    chk("t6_clean", 128'(err_o), 128'(0));

    // Random rounds.
    for (int rr = 0; rr < 4; rr++) begin
      start();
      for (int c = 0; c < 80; c++) begin
        r = mk($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 5),
               ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom));
        dp = ($urandom_range(0, 2) == 0);
        if (mq.size() != 0) begin
          db = ($urandom_range(0, 9) < 7);
          d  = cur_exp();
          if ($urandom_range(0, 7) == 0) d = d ^ (128'h1 << $urandom_range(0, 127));
        end else begin
          db = ($urandom_range(0, 29) == 0);
          d  = {$urandom, $urandom, $urandom, $urandom};
        end
        cycle(dp, r, db, d, 0);
      end
      while (mq.size() != 0) beat(cur_exp());
      idle(3);
    end

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
